// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write path (value port + commit tag-clear port) among NREQ writers.
// Define REGWR_RR_ARB_EN for round-robin arbitration; otherwise the lowest requester index wins.
module regfile_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [5*NREQ-1:0]       req_reg,
  input  logic [32*NREQ-1:0]      req_val,
  input  logic [TAG_W*NREQ-1:0]   req_tag,
  output logic [4:0]              set_reg,
  output logic [31:0]             set_val,
  output logic [4:0]              set_reg_q,
  output logic [31:0]             set_val_q,
  output logic [2:0]              grant_id
);

  localparam int LANES = 8;

  // Requests are unpacked into a fixed 8-lane view so a 3-bit winner index always addresses a lane.
  logic [LANES-1:0] valid_pad;
  logic [4:0]       reg_lane [LANES];
  logic [31:0]      val_lane [LANES];
  logic [31:0]      tag_lane [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi < NREQ) begin : g_live
        assign valid_pad[gi] = req_valid[gi];
        assign reg_lane[gi]  = req_reg[gi*5 +: 5];
        assign val_lane[gi]  = req_val[gi*32 +: 32];
        assign tag_lane[gi]  = 32'(req_tag[gi*TAG_W +: TAG_W]);
      end else begin : g_pad
        assign valid_pad[gi] = 1'b0;
        assign reg_lane[gi]  = '0;
        assign val_lane[gi]  = '0;
        assign tag_lane[gi]  = '0;
      end
    end
  endgenerate

  logic       arb_enable;
  logic       xfer;
  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;

  assign arb_enable = rst_in & rdy_in & ~flush_in;
  assign xfer       = arb_enable & win_found;

`ifdef REGWR_RR_ARB_EN
  logic [2:0] ptr_reg;
  logic [2:0] ptr_next;
  logic [3:0] scan_sum;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_reg} + 4'(k);
      if (scan_sum >= 4'(NREQ)) scan_sum = scan_sum - 4'(NREQ);
      scan_idx = scan_sum[2:0];
      if (!win_found && valid_pad[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  assign ptr_next = (win_idx == 3'(NREQ-1)) ? 3'd0 : win_idx + 3'd1;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ptr_reg <= '0;
    end else if (xfer) begin
      ptr_reg <= ptr_next;
    end
  end
`else
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = 3'(k);
      if (!win_found && valid_pad[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = xfer && (win_idx == 3'(gi));
    end
  endgenerate

  // Idle or flushed cycles clear only the indices; data and grant_id keep their last winner for trace.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      set_reg   <= '0;
      set_val   <= '0;
      set_reg_q <= '0;
      set_val_q <= '0;
      grant_id  <= '0;
    end else if (rdy_in) begin
      if (xfer) begin
        set_reg   <= reg_lane[win_idx];
        set_reg_q <= reg_lane[win_idx];
        set_val   <= val_lane[win_idx];
        set_val_q <= tag_lane[win_idx];
        grant_id  <= win_idx;
      end else begin
        set_reg   <= '0;
        set_reg_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter; expectations follow REGWR_RR_ARB_EN when defined.
module tb_regfile_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int TAG_W = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic [3:0]  req_valid, req_ready;
  logic [19:0] req_reg;
  logic [127:0] req_val;
  logic [15:0] req_tag;
  logic [4:0]  set_reg, set_reg_q;
  logic [31:0] set_val, set_val_q;
  logic [2:0]  grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  m_reg [4];
  logic [31:0] m_val [4];
  logic [3:0]  m_tag [4];

  always #5 clk_in = ~clk_in;

  regfile_wr_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val), .req_tag(req_tag),
    .set_reg(set_reg), .set_val(set_val), .set_reg_q(set_reg_q),
    .set_val_q(set_val_q), .grant_id(grant_id)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] v, input logic [3:0] t);
    m_reg[i] = r;
    m_val[i] = v;
    m_tag[i] = t;
    req_reg[i*5 +: 5]   = r;
    req_val[i*32 +: 32] = v;
    req_tag[i*4 +: 4]   = t;
  endtask

  task automatic test_reset;
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; req_valid = 4'b1111;
    tick; tick;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (set_reg !== 5'd0) begin n_bad++; $display("FAIL reset_set_reg: got %0d want 0", set_reg); end
    n_cmp++; if (set_val !== 32'd0) begin n_bad++; $display("FAIL reset_set_val: got %h want 0", set_val); end
    n_cmp++; if (set_reg_q !== 5'd0) begin n_bad++; $display("FAIL reset_set_reg_q: got %0d want 0", set_reg_q); end
    n_cmp++; if (set_val_q !== 32'd0) begin n_bad++; $display("FAIL reset_set_val_q: got %h want 0", set_val_q); end
    n_cmp++; if (grant_id !== 3'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    rst_in = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
    $display("reset: ready=%b set_reg=%0d grant_id=%0d", req_ready, set_reg, grant_id);
  endtask

  task automatic test_round_robin;
    int exp;
    logic [3:0] exp_rdy;
    for (int c = 0; c < 5; c++) begin
`ifdef REGWR_RR_ARB_EN
      exp = c % 4;
`else
      exp = 0;
`endif
      exp_rdy = 4'b0001 << exp;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
      tick;
      n_cmp++; if (set_reg !== m_reg[exp]) begin n_bad++; $display("FAIL rr_set_reg[%0d]: got %0d want %0d", c, set_reg, m_reg[exp]); end
      n_cmp++; if (set_reg_q !== m_reg[exp]) begin n_bad++; $display("FAIL rr_set_reg_q[%0d]: got %0d want %0d", c, set_reg_q, m_reg[exp]); end
      n_cmp++; if (set_val !== m_val[exp]) begin n_bad++; $display("FAIL rr_set_val[%0d]: got %h want %h", c, set_val, m_val[exp]); end
      n_cmp++; if (set_val_q !== {28'h0, m_tag[exp]}) begin n_bad++; $display("FAIL rr_set_val_q[%0d]: got %h want %h", c, set_val_q, {28'h0, m_tag[exp]}); end
      n_cmp++; if (grant_id !== 3'(exp)) begin n_bad++; $display("FAIL rr_grant_id[%0d]: got %0d want %0d", c, grant_id, exp); end
      $display("rr %0d: grant_id=%0d set_reg=%0d set_val=%h set_val_q=%h", c, grant_id, set_reg, set_val, set_val_q);
    end
  endtask

  task automatic test_x0_drop;
    logic [3:0] exp_rdy;
    set_req(1, 5'd0, 32'hDEADBEEF, 4'h5);
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL x0_ready: got %b want 0010", req_ready); end
    tick;
    n_cmp++; if (set_reg !== 5'd0) begin n_bad++; $display("FAIL x0_set_reg: got %0d want 0", set_reg); end
    n_cmp++; if (set_reg_q !== 5'd0) begin n_bad++; $display("FAIL x0_set_reg_q: got %0d want 0", set_reg_q); end
    n_cmp++; if (set_val !== 32'hDEADBEEF) begin n_bad++; $display("FAIL x0_set_val: got %h want deadbeef", set_val); end
    n_cmp++; if (grant_id !== 3'd1) begin n_bad++; $display("FAIL x0_grant_id: got %0d want 1", grant_id); end
    req_valid = 4'b1111;
    #1;
`ifdef REGWR_RR_ARB_EN
    exp_rdy = 4'b0100;
`else
    exp_rdy = 4'b0001;
`endif
    n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL x0_ptr_advance: got %b want %b", req_ready, exp_rdy); end
    $display("x0: set_reg=%0d set_val=%h grant_id=%0d next_ready=%b", set_reg, set_val, grant_id, req_ready);
    set_req(1, 5'd11, 32'h1000_0001, 4'hB);
  endtask

  task automatic test_flush;
    logic [3:0] exp_rdy;
    set_req(2, 5'd5, 32'h5555_0002, 4'h2);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL flush_pre_ready: got %b want 0100", req_ready); end
    tick;
    n_cmp++; if (set_reg !== 5'd5) begin n_bad++; $display("FAIL flush_pre_set_reg: got %0d want 5", set_reg); end
    flush_in = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_ready: got %b want 0000", req_ready); end
    tick;
    n_cmp++; if (set_reg !== 5'd0) begin n_bad++; $display("FAIL flush_set_reg: got %0d want 0", set_reg); end
    n_cmp++; if (set_reg_q !== 5'd0) begin n_bad++; $display("FAIL flush_set_reg_q: got %0d want 0", set_reg_q); end
    n_cmp++; if (grant_id !== 3'd2) begin n_bad++; $display("FAIL flush_grant_id: got %0d want 2", grant_id); end
    n_cmp++; if (set_val !== 32'h5555_0002) begin n_bad++; $display("FAIL flush_set_val: got %h want 55550002", set_val); end
    flush_in = 1'b0;
    #1;
`ifdef REGWR_RR_ARB_EN
    exp_rdy = 4'b1000;
`else
    exp_rdy = 4'b0001;
`endif
    n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL flush_ptr_hold: got %b want %b", req_ready, exp_rdy); end
    $display("flush: set_reg=%0d grant_id=%0d next_ready=%b", set_reg, grant_id, req_ready);
  endtask

  task automatic test_stall;
    set_req(3, 5'd7, 32'h12345678, 4'h7);
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL stall_pre_ready: got %b want 1000", req_ready); end
    tick;
    n_cmp++; if (set_reg !== 5'd7) begin n_bad++; $display("FAIL stall_pre_set_reg: got %0d want 7", set_reg); end
    rdy_in = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, req_ready); end
      tick;
      n_cmp++; if (set_reg !== 5'd7) begin n_bad++; $display("FAIL stall_set_reg[%0d]: got %0d want 7", c, set_reg); end
      n_cmp++; if (set_reg_q !== 5'd7) begin n_bad++; $display("FAIL stall_set_reg_q[%0d]: got %0d want 7", c, set_reg_q); end
      n_cmp++; if (set_val !== 32'h12345678) begin n_bad++; $display("FAIL stall_set_val[%0d]: got %h want 12345678", c, set_val); end
      n_cmp++; if (grant_id !== 3'd3) begin n_bad++; $display("FAIL stall_grant_id[%0d]: got %0d want 3", c, grant_id); end
      $display("stall %0d: ready=%b set_reg=%0d set_val=%h", c, req_ready, set_reg, set_val);
    end
    rdy_in = 1'b1;
    req_valid = 4'b1110;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL stall_resume_ready: got %b want 0010", req_ready); end
    tick;
    n_cmp++; if (set_reg !== 5'd11) begin n_bad++; $display("FAIL stall_resume_set_reg: got %0d want 11", set_reg); end
    n_cmp++; if (grant_id !== 3'd1) begin n_bad++; $display("FAIL stall_resume_grant_id: got %0d want 1", grant_id); end
    $display("resume: set_reg=%0d grant_id=%0d", set_reg, grant_id);
  endtask

  task automatic test_back_to_back;
    int exp;
    logic [3:0] exp_rdy;
    req_valid = 4'b1001;
    for (int c = 0; c < 4; c++) begin
`ifdef REGWR_RR_ARB_EN
      exp = (c % 2 == 0) ? 3 : 0;
`else
      exp = 0;
`endif
      exp_rdy = 4'b0001 << exp;
      #1;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
      tick;
      n_cmp++; if (grant_id !== 3'(exp)) begin n_bad++; $display("FAIL b2b_grant_id[%0d]: got %0d want %0d", c, grant_id, exp); end
      n_cmp++; if (set_reg !== m_reg[exp]) begin n_bad++; $display("FAIL b2b_set_reg[%0d]: got %0d want %0d", c, set_reg, m_reg[exp]); end
      $display("b2b %0d: grant_id=%0d set_reg=%0d", c, grant_id, set_reg);
    end
  endtask

  initial begin
    req_reg = '0; req_val = '0; req_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 5'(10 + i), 32'h1000_0000 + 32'(i), 4'(10 + i));
    end
    test_reset;
    test_round_robin;
    test_x0_drop;
    test_flush;
    test_stall;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
